// File: rtl/sand_pkg.sv
// Shared cell types, register offsets and screen geometry for the sand fabric.
package sand_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        SAND  = 2'd1,
        WATER = 2'd2,
        WALL  = 2'd3
    } cell_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int PX_W     = 11;
    localparam int PY_W     = 10;

    // Offsets 0-3 belong to the kernel command block.
    localparam logic [2:0] ADDR_X      = 3'd0;
    localparam logic [2:0] ADDR_Y      = 3'd1;
    localparam logic [2:0] ADDR_CMD    = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_PX     = 3'd4;
    localparam logic [2:0] ADDR_PY     = 3'd5;
    localparam logic [2:0] ADDR_CELL   = 3'd6;
    localparam logic [2:0] ADDR_RSTAT  = 3'd7;

    localparam logic [15:0] OOB_DATA = 16'hFFFF;

endpackage

// File: rtl/sand_readback_if.sv
// HPS Avalon-MM kernel port plus the screen row memory read port.
interface sand_readback_if
    import sand_pkg::*;
#(
    parameter int ROW_BITS = SCREEN_W * $bits(cell_t)
);
    logic                kernel_chipselect;
    logic                kernel_read;
    logic                kernel_write;
    logic [2:0]          kernel_address;
    logic [15:0]         kernel_writedata;
    logic [15:0]         kernel_readdata;
    logic                kernel_waitrequest;
    logic                mem_rd;
    logic [PY_W-1:0]     mem_row_addr;
    logic [ROW_BITS-1:0] mem_row_data;

    modport slave (
        input  kernel_chipselect, kernel_read, kernel_write, kernel_address,
               kernel_writedata, mem_row_data,
        output kernel_readdata, kernel_waitrequest, mem_rd, mem_row_addr
    );

    modport master (
        output kernel_chipselect, kernel_read, kernel_write, kernel_address,
               kernel_writedata, mem_row_data,
        input  kernel_readdata, kernel_waitrequest, mem_rd, mem_row_addr
    );
endinterface

// File: rtl/sand_cell_mux.sv
// Selects one cell out of a packed screen row; shared with the render path.
module sand_cell_mux
    import sand_pkg::*;
#(
    parameter int WIDTH     = SCREEN_W,
    parameter int CELL_BITS = $bits(cell_t)
) (
    input  logic [WIDTH*CELL_BITS-1:0] row_i,
    input  logic [PX_W-1:0]            x_i,
    output cell_t                      cell_o
);
    localparam int IDX_W = $clog2(WIDTH * CELL_BITS);

    logic [IDX_W-1:0] lsb;

    assign lsb    = IDX_W'(x_i) * IDX_W'(CELL_BITS);
    assign cell_o = cell_t'(row_i[lsb +: CELL_BITS]);
endmodule

// File: rtl/sand_readback.sv
// HPS probe readback: fetch a screen row, return the 2-bit cell at (probe_x, probe_y).
module sand_readback
    import sand_pkg::*;
#(
    parameter int WIDTH       = SCREEN_W,
    parameter int HEIGHT      = SCREEN_H,
    parameter int CELL_BITS   = 2,
    parameter int MEM_LATENCY = 2
) (
    input  logic           clock,
    input  logic           reset,
    sand_readback_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    logic [1:0]      state_q, state_d;
    logic [PX_W-1:0] probe_x_q, probe_x_d, fetch_x_q, fetch_x_d;
    logic [PY_W-1:0] probe_y_q, probe_y_d, row_addr_q, row_addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]      count_q, count_d;
    logic            oob_q, oob_d, mem_rd_q, mem_rd_d;
    logic [15:0]     cell_q, cell_d, status;
    logic            cell_req, in_range, unused_wdata;
    cell_t           cell_sel;

    sand_cell_mux #(.WIDTH(WIDTH), .CELL_BITS(CELL_BITS)) u_mux (
        .row_i  (bus.mem_row_data),
        .x_i    (fetch_x_q),
        .cell_o (cell_sel)
    );

    assign cell_req = bus.kernel_chipselect && bus.kernel_read && (bus.kernel_address == ADDR_CELL);
    assign in_range = (probe_x_q < PX_W'(WIDTH)) && (probe_y_q < PY_W'(HEIGHT));
    assign status   = {count_q, 6'b0, oob_q, state_q != S_IDLE};
    assign unused_wdata = ^bus.kernel_writedata[15:PX_W];

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block can infer a latch.
        state_d    = state_q;
        probe_x_d  = probe_x_q;
        probe_y_d  = probe_y_q;
        fetch_x_d  = fetch_x_q;
        row_addr_d = row_addr_q;
        cnt_d      = cnt_q;
        count_d    = count_q;
        oob_d      = oob_q;
        cell_d     = cell_q;
        mem_rd_d   = 1'b0;

        if (bus.kernel_chipselect && bus.kernel_write) begin
            if (bus.kernel_address == ADDR_PX) probe_x_d = bus.kernel_writedata[PX_W-1:0];
            if (bus.kernel_address == ADDR_PY) probe_y_d = bus.kernel_writedata[PY_W-1:0];
        end

        // A read that drops before DONE is abandoned; late row data is simply never captured.
        case (state_q)
            S_IDLE: if (cell_req) begin
                if (in_range) begin
                    state_d    = S_FETCH;
                    mem_rd_d   = 1'b1;
                    row_addr_d = probe_y_q;
                    fetch_x_d  = probe_x_q;
                end else begin
                    state_d = S_DONE;
                    cell_d  = OOB_DATA;
                    oob_d   = 1'b1;
                end
            end
            S_FETCH: begin
                state_d = cell_req ? S_WAIT : S_IDLE;
                cnt_d   = CNT_W'(MEM_LATENCY - 1);
            end
            S_WAIT: begin
                if (!cell_req) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_DONE;
                    cell_d  = 16'(cell_sel);
                    oob_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                if (cell_req) count_d = count_q + 8'd1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
        if (!reset) begin
            state_q    <= S_IDLE;
            probe_x_q  <= '0;
            probe_y_q  <= '0;
            fetch_x_q  <= '0;
            row_addr_q <= '0;
            cnt_q      <= '0;
            count_q    <= '0;
            oob_q      <= 1'b0;
            cell_q     <= '0;
            mem_rd_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            probe_x_q  <= probe_x_d;
            probe_y_q  <= probe_y_d;
            fetch_x_q  <= fetch_x_d;
            row_addr_q <= row_addr_d;
            cnt_q      <= cnt_d;
            count_q    <= count_d;
            oob_q      <= oob_d;
            cell_q     <= cell_d;
            mem_rd_q   <= mem_rd_d;
        end
    end

    // Bus responses are combinational so non-stalling reads finish in the cycle presented.
    assign bus.kernel_waitrequest = reset && cell_req && (state_q != S_DONE);
    assign bus.mem_rd             = mem_rd_q;
    assign bus.mem_row_addr       = row_addr_q;

    always_comb begin
        bus.kernel_readdata = '0;
        if (reset) begin
            if (bus.kernel_address == ADDR_CELL)  bus.kernel_readdata = cell_q;
            if (bus.kernel_address == ADDR_RSTAT) bus.kernel_readdata = status;
        end
    end
endmodule

// File: tb/tb_sand_readback.sv
// Self-checking bench for sand_readback: vector table, directed corner cases, random traffic.
module tb_sand_readback
    import sand_pkg::*;
;
    localparam int W = 640;
    localparam int H = 480;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   gen = 0;

    logic [10:0] px_m = '0;
    logic [9:0]  py_m = '0;
    logic [7:0]  count_m = '0;
    logic        oob_m = 1'b0;

    sand_readback_if #(.ROW_BITS(W * 2)) bus ();

    sand_readback #(.WIDTH(W), .HEIGHT(H), .CELL_BITS(2), .MEM_LATENCY(2)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Screen contents as a plain function of (y, x, gen); two fixed cells for the directed cases.
    function automatic logic [1:0] cell_of(input int y, input int x);
        if (y == 3 && x == 5) return 2'd2;
        if (y == 479 && x == 639) return 2'd3;
        return 2'((x * 7) + (y * 13) + (x / 5) + (gen * 5));
    endfunction

    function automatic logic [W*2-1:0] row_of(input logic [9:0] y);
        logic [W*2-1:0] r;
        for (int x = 0; x < W; x++) r[x*2 +: 2] = cell_of(int'(y), x);
        return r;
    endfunction

    // Row memory: data is valid two clocks after mem_rd, inverted garbage otherwise.
    logic       d1 = 1'b0;
    logic [9:0] a1 = '0;
    always @(posedge clk) begin
        d1 <= bus.mem_rd;
        a1 <= bus.mem_row_addr;
        bus.mem_row_data <= d1 ? row_of(a1) : ~row_of(bus.mem_row_addr);
    end

    typedef struct {
        logic [15:0] wx;
        logic [15:0] wy;
        logic [15:0] exp_data;
        int          exp_wait;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive_idle();
        bus.kernel_chipselect = 1'b0;
        bus.kernel_read       = 1'b0;
        bus.kernel_write      = 1'b0;
        bus.kernel_address    = '0;
        bus.kernel_writedata  = '0;
    endtask

    function automatic logic [15:0] status_exp();
        return {count_m, 6'b0, oob_m, 1'b0};
    endfunction

    function automatic logic model_in_range();
        return (px_m < 11'(W)) && (py_m < 10'(H));
    endfunction

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        bus.kernel_chipselect = 1'b1;
        bus.kernel_write      = 1'b1;
        bus.kernel_read       = 1'b0;
        bus.kernel_address    = a;
        bus.kernel_writedata  = d;
        @(posedge clk); #1;
        drive_idle();
        if (a == ADDR_PX) px_m = d[10:0];
        if (a == ADDR_PY) py_m = d[9:0];
    endtask

    task automatic rd_imm(input logic [2:0] a, input logic [15:0] exp, input string nm);
        bus.kernel_chipselect = 1'b1;
        bus.kernel_read       = 1'b1;
        bus.kernel_address    = a;
        @(negedge clk);
        check({nm, " waitreq"}, bus.kernel_waitrequest, 1'b0);
        check({nm, " data"}, bus.kernel_readdata, exp);
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic rd_cell(input string nm, input logic [15:0] exp, input int exp_wait);
        int          waits = 0;
        int          fetches = 0;
        bit          done = 1'b0;
        logic [15:0] got = '0;
        logic [9:0]  fa = '0;
        logic [9:0]  ey = py_m;
        bus.kernel_chipselect = 1'b1;
        bus.kernel_read       = 1'b1;
        bus.kernel_address    = ADDR_CELL;
        for (int c = 0; c < 16 && !done; c++) begin
            @(negedge clk);
            if (bus.mem_rd) begin
                fetches++;
                fa = bus.mem_row_addr;
            end
            if (bus.kernel_waitrequest) waits++;
            else begin
                done = 1'b1;
                got  = bus.kernel_readdata;
            end
            @(posedge clk); #1;
        end
        drive_idle();
        check({nm, " completed"}, 32'(done), 32'd1);
        check({nm, " data"}, got, exp);
        check({nm, " wait cycles"}, waits, exp_wait);
        check({nm, " fetches"}, fetches, (exp_wait > 1) ? 1 : 0);
        if (exp_wait > 1) check({nm, " row addr"}, fa, ey);
        count_m++;
        oob_m = (exp_wait == 1);
    endtask

    task automatic read_cell(input string nm);
        if (model_in_range()) rd_cell(nm, 16'(cell_of(int'(py_m), int'(px_m))), 4);
        else                  rd_cell(nm, OOB_DATA, 1);
    endtask

    initial begin
        vecs[0] = '{16'd5,     16'd3,     16'h0002, 4};
        vecs[1] = '{16'd639,   16'd479,   16'h0003, 4};
        vecs[2] = '{16'd640,   16'd479,   16'hFFFF, 1};
        vecs[3] = '{16'd0,     16'd480,   16'hFFFF, 1};
        vecs[4] = '{16'h07FF,  16'h03FF,  16'hFFFF, 1};
        vecs[5] = '{16'd0,     16'd0,     16'(cell_of(0, 0)), 4};
        vecs[6] = '{16'd639,   16'd0,     16'(cell_of(0, 639)), 4};
        vecs[7] = '{16'hF805,  16'hFC03,  16'h0002, 4};

        drive_idle();
        // Reset with a cell read pending: no stall may be reported.
        repeat (2) @(posedge clk);
        #1;
        bus.kernel_chipselect = 1'b1;
        bus.kernel_read       = 1'b1;
        bus.kernel_address    = ADDR_CELL;
        @(negedge clk);
        check("reset waitreq", bus.kernel_waitrequest, 1'b0);
        check("reset readdata", bus.kernel_readdata, 16'h0000);
        check("reset mem_rd", bus.mem_rd, 1'b0);
        @(posedge clk); #1;
        drive_idle();
        rst_n = 1'b1;

        rd_imm(ADDR_RSTAT, 16'h0000, "status after reset");
        rd_imm(ADDR_X, 16'h0000, "offset0 after reset");

        for (int i = 0; i < 8; i++) begin
            wr(ADDR_PX, vecs[i].wx);
            wr(ADDR_PY, vecs[i].wy);
            rd_cell($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_wait);
            rd_imm(ADDR_RSTAT, status_exp(), $sformatf("vec%0d status", i));
        end
        rd_imm(ADDR_PX, 16'h0000, "probe_x write-only");

        // Drop the read during WAIT: no count, then a fresh fetch with new memory contents.
        wr(ADDR_PX, 16'd100);
        wr(ADDR_PY, 16'd200);
        bus.kernel_chipselect = 1'b1;
        bus.kernel_read       = 1'b1;
        bus.kernel_address    = ADDR_CELL;
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive_idle();
        @(posedge clk); #1;
        rd_imm(ADDR_RSTAT, status_exp(), "abort status");
        gen++;
        wr(ADDR_PX, 16'd101);
        read_cell("after abort");

        // Read and write presented together on the probe register.
        bus.kernel_chipselect = 1'b1;
        bus.kernel_read       = 1'b1;
        bus.kernel_write      = 1'b1;
        bus.kernel_address    = ADDR_PX;
        bus.kernel_writedata  = 16'd7;
        @(negedge clk);
        check("rw waitreq", bus.kernel_waitrequest, 1'b0);
        check("rw data", bus.kernel_readdata, 16'h0000);
        @(posedge clk); #1;
        drive_idle();
        px_m = 11'd7;
        read_cell("after rw");

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 6))
                0: wr(ADDR_PX, {5'($urandom), 11'($urandom_range(0, 700))});
                1: wr(ADDR_PY, {6'($urandom), 10'($urandom_range(0, 520))});
                2: wr(3'($urandom_range(0, 3)), 16'($urandom));
                3: rd_imm(3'($urandom_range(0, 5)), 16'h0000, "rand low offset");
                4: rd_imm(ADDR_RSTAT, status_exp(), "rand status");
                default: begin
                    if ($urandom_range(0, 3) == 0) gen++;
                    read_cell("rand cell");
                end
            endcase
        end

        // Reset while the fetch is waiting on memory.
        wr(ADDR_PX, 16'd300);
        wr(ADDR_PY, 16'd100);
        bus.kernel_chipselect = 1'b1;
        bus.kernel_read       = 1'b1;
        bus.kernel_address    = ADDR_CELL;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid reset waitreq", bus.kernel_waitrequest, 1'b0);
        check("mid reset readdata", bus.kernel_readdata, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_idle();
        px_m = '0;
        py_m = '0;
        count_m = '0;
        oob_m = 1'b0;
        @(negedge clk);
        check("post reset mem_rd", bus.mem_rd, 1'b0);
        @(posedge clk); #1;
        rd_imm(ADDR_RSTAT, 16'h0000, "post reset status");

        // Counter wrap: 256 back-to-back cell reads.
        wr(ADDR_PX, 16'd640);
        for (int i = 0; i < 255; i++) rd_cell("wrap read", OOB_DATA, 1);
        rd_imm(ADDR_RSTAT, 16'hFF02, "count 255 status");
        rd_cell("wrap final read", OOB_DATA, 1);
        rd_imm(ADDR_RSTAT, 16'h0002, "count wrap status");
        wr(ADDR_PX, 16'd0);
        read_cell("after wrap");
        rd_imm(ADDR_RSTAT, status_exp(), "after wrap status");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sand_readback.md
Name: sand_readback

Overview:
- Avalon-MM slave read path from the HPS into the sand fabric; the complement of the existing write-only kernel command registers.
- The HPS writes a probe coordinate, then reads the 2-bit cell type stored at that coordinate.
- The block fetches the full cell row from the screen row memory with fixed latency and selects the addressed cell.
- It stalls the bus with waitrequest until the data is ready.

Parameters:
- WIDTH, 640, cells per row
- HEIGHT, 480, rows
- CELL_BITS, 2, bits per cell type
- MEM_LATENCY, 2, clocks from mem_rd to valid mem_row_data (>=1)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- kernel_chipselect  in  1  slave select (shared with the command registers)
- kernel_read  in  1  read strobe
- kernel_write  in  1  write strobe
- kernel_address  in  3  register offset
- kernel_writedata  in  16  write payload
- kernel_readdata  out  16  read payload
- kernel_waitrequest  out  1  stall the current read
- mem_rd  out  1  one-cycle row fetch request
- mem_row_addr  out  10  row index (y)
- mem_row_data  in  WIDTH*CELL_BITS  row contents, valid MEM_LATENCY clocks after mem_rd

Behaviour:
- Register map. Offsets 0-3 are owned by the command block; this block ignores them and returns readdata 0 for them.
  - 4 W: probe_x <= writedata[10:0]
  - 5 W: probe_y <= writedata[9:0]
  - 6 R: cell type, zero-extended. Stalls.
  - 7 R: status = {read_count[7:0], 6'b0, last_oob, busy}
- Reset (reset==0 at a clock edge) clears all state: probe_x=0, probe_y=0, state=IDLE, read_count=0, last_oob=0, mem_rd=0, mem_row_addr=0, kernel_readdata=0. kernel_waitrequest is 0 during reset.
- Waitrequest is combinational. It is 1 when chipselect && read && address==6 && state!=DONE; otherwise 0. Reads of 0-5 and 7 complete with zero wait states, and readdata is valid in that same cycle.
- FSM states: IDLE, FETCH, WAIT, DONE.
  - IDLE -> FETCH: on chipselect && read && address==6 with an in-range coordinate (probe_x<WIDTH, probe_y<HEIGHT).
  - IDLE -> DONE: for an out-of-range coordinate. No fetch is issued; readdata=16'hFFFF and last_oob=1.
  - FETCH: mem_rd=1 for exactly one cycle, mem_row_addr=probe_y. Go to WAIT and load the latency counter with MEM_LATENCY-1.
  - WAIT: decrement each cycle. At 0, capture mem_row_data[probe_x*CELL_BITS +: CELL_BITS] into readdata, set last_oob=0, go to DONE.
  - DONE: waitrequest=0 and the read completes this cycle. read_count increments (8-bit, wraps 255->0). Return to IDLE.
- Latency: an in-range read completes MEM_LATENCY+2 clocks after the read is first presented. An out-of-range read completes 1 clock after.
- The coordinate is sampled at the IDLE->FETCH transition. Writes to 4/5 while busy update the registers but do not affect the fetch in flight.
- busy=1 in FETCH/WAIT/DONE.
- Master drops read before DONE: abandon the fetch, return to IDLE next cycle, no count increment. Late mem_row_data is ignored.
- Read and write asserted together: write is serviced, read follows its normal path.
- Reset mid-fetch: immediate return to IDLE; an outstanding memory response is ignored.

Decomposition:
- Package sand_pkg:
  - cell_t (2-bit enum EMPTY=0, SAND=1, WATER=2, WALL=3)
  - register offset constants ADDR_X..ADDR_STATUS, ADDR_PX=4, ADDR_PY=5, ADDR_CELL=6, ADDR_RSTAT=7
  - OOB_DATA=16'hFFFF
  - screen dimensions
- Sub-module sand_cell_mux: combinational row-to-cell select (row, x -> cell_t), reused by the render path.

Test Plan:
- Reset then read offset 7 -> readdata=16'h0000, waitrequest=0 in the same cycle.
- Write 4<=5, 5<=3; memory row 3 has cell 5 = WATER; read 6 -> mem_rd one cycle with mem_row_addr=3, waitrequest high 4 cycles (MEM_LATENCY=2), readdata=16'h0002. Then read 7 -> 16'h0100.
- Write 4<=639, 5<=479, cell = WALL -> readdata=3 (top-edge bit select). Write 4<=640 -> readdata=16'hFFFF after 1 cycle, no mem_rd, status bit1=1.
- Start read 6, deassert read during WAIT -> FSM back to IDLE, read_count unchanged, next read returns fresh data.
- Drive reset low during WAIT -> waitrequest=0, state IDLE, status=0 after release.
- 256 back-to-back cell reads -> read_count wraps to 0, status[15:8]=0.
